// File: rtl/h263_quantizer.sv
// Purpose  : H.263 quantizer, 8x8 DCT coefficients in (raster order) -> quantized levels out (same order).
// Latency  : 3 cycles accept-to-output, 1 coefficient/cycle.
// Backpress: single global advance (en = !v3 || i_axis_TREADY); o_axis_TREADY = en, outputs hold while stalled.
//
// Ports: i_clk/i_reset (sync, active-high); i_qp/i_intra sampled on coefficient 0 of each block;
//   i_axis_* input coefficient stream (low VALUE_WIDTH bits of TDATA, SCALE fractional bits);
//   o_axis_* quantized level stream, TLAST regenerated from the coefficient index;
//   o_tlast_err pulses (registered, cycle after the offending accept) on block framing errors.
// Optional build macro QUANT_STATS_EN adds o_nz_count / o_block_done (nonzero levels per block).
module h263_quantizer #(
  parameter int VALUE_WIDTH = 17,
  parameter int SCALE       = 7,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic [4:0]                           i_qp,
  input  logic                                 i_intra,
  input  logic                                 i_axis_TVALID,
  output logic                                 o_axis_TREADY,
  input  logic [8*((VALUE_WIDTH-1)/8+1)-1:0]   i_axis_TDATA,
  input  logic                                 i_axis_TLAST,
  output logic                                 o_axis_TVALID,
  input  logic                                 i_axis_TREADY,
  output logic [OUT_WIDTH-1:0]                 o_axis_TDATA,
  output logic                                 o_axis_TLAST,
`ifdef QUANT_STATS_EN
  output logic [6:0]                           o_nz_count,
  output logic                                 o_block_done,
`endif
  output logic                                 o_tlast_err
);

  // |COF| never exceeds 2^(VALUE_WIDTH-1-SCALE), which needs VALUE_WIDTH-SCALE bits.
  localparam int MAG_W = VALUE_WIDTH - SCALE;
  localparam logic [VALUE_WIDTH-1:0]   HALF    = VALUE_WIDTH'(1) << (SCALE - 1);
  localparam logic signed [MAG_W+1:0]  DC_BIAS = (MAG_W+2)'(4);
  localparam logic signed [MAG_W+1:0]  DC_MIN  = (MAG_W+2)'(1);
  localparam logic signed [MAG_W+1:0]  DC_MAX  = (MAG_W+2)'(254);

  // RECIP[qp] = floor(65536 / (2*qp)); entry 0 is never addressed (qp 0 is mapped to 1).
  function automatic logic [15:0] recip_lut(input logic [4:0] qp);
    case (qp)
      5'd1:  recip_lut = 16'd32768;  5'd2:  recip_lut = 16'd16384;
      5'd3:  recip_lut = 16'd10922;  5'd4:  recip_lut = 16'd8192;
      5'd5:  recip_lut = 16'd6553;   5'd6:  recip_lut = 16'd5461;
      5'd7:  recip_lut = 16'd4681;   5'd8:  recip_lut = 16'd4096;
      5'd9:  recip_lut = 16'd3640;   5'd10: recip_lut = 16'd3276;
      5'd11: recip_lut = 16'd2978;   5'd12: recip_lut = 16'd2730;
      5'd13: recip_lut = 16'd2520;   5'd14: recip_lut = 16'd2340;
      5'd15: recip_lut = 16'd2184;   5'd16: recip_lut = 16'd2048;
      5'd17: recip_lut = 16'd1927;   5'd18: recip_lut = 16'd1820;
      5'd19: recip_lut = 16'd1724;   5'd20: recip_lut = 16'd1638;
      5'd21: recip_lut = 16'd1560;   5'd22: recip_lut = 16'd1489;
      5'd23: recip_lut = 16'd1424;   5'd24: recip_lut = 16'd1365;
      5'd25: recip_lut = 16'd1310;   5'd26: recip_lut = 16'd1260;
      5'd27: recip_lut = 16'd1213;   5'd28: recip_lut = 16'd1170;
      5'd29: recip_lut = 16'd1129;   5'd30: recip_lut = 16'd1092;
      5'd31: recip_lut = 16'd1057;
      default: recip_lut = 16'd32768;
    endcase
  endfunction

  // Block-level state
  logic [5:0]  idx_q, idx_d;
  logic [4:0]  qp_l_q, qp_l_d;
  logic        intra_l_q, intra_l_d;
  logic        err_q, err_d;
  // Stage 1: rounded magnitude
  logic             v1_q, v1_d, sign1_q, sign1_d, intra1_q, intra1_d;
  logic [MAG_W-1:0] mag1_q, mag1_d;
  logic [5:0]       idx1_q, idx1_d;
  logic [4:0]       qp1_q, qp1_d;
  // Stage 2: reciprocal-multiply estimate
  logic             v2_q, v2_d, sign2_q, sign2_d, intra2_q, intra2_d;
  logic [MAG_W-1:0] mag2_q, mag2_d, magp2_q, magp2_d, q2_q, q2_d;
  logic [5:0]       idx2_q, idx2_d;
  logic [4:0]       qp2_q, qp2_d;
  // Stage 3: output register
  logic                 v3_q, v3_d, last3_q, last3_d;
  logic [OUT_WIDTH-1:0] dat3_q, dat3_d;

  logic en, accept;
  logic [4:0]  qp_in, qp_cur;
  logic        intra_cur;
  logic [VALUE_WIDTH-1:0] coef, abs_in, rnd;
  logic [MAG_W-1:0]       mag_in, half_qp, magp, q_est;
  logic [MAG_W+15:0]      prod;
  logic [MAG_W:0]         q_inc, q_fix;
  logic [MAG_W+6:0]       corr_prod;
  logic [6:0]             mag_lim;
  logic [OUT_WIDTH-1:0]   ac_lvl;
  logic signed [MAG_W+1:0] dc_cof, dc_sum, dc_shr;
  logic [7:0]             dc_lvl;
  logic                   is_dc;
  logic                   unused_sink;

  assign en            = !v3_q || i_axis_TREADY;
  assign o_axis_TREADY = en && !i_reset;
  assign accept        = i_axis_TVALID && o_axis_TREADY;

  assign o_axis_TVALID = v3_q;
  assign o_axis_TDATA  = dat3_q;
  assign o_axis_TLAST  = last3_q;
  assign o_tlast_err   = err_q;

  // Fractional bits of the rounded value, product fraction and TDATA padding carry no information.
  assign unused_sink = ^{i_axis_TDATA >> VALUE_WIDTH, rnd[SCALE-1:0], prod[15:0]};

  // Datapath
  always_comb begin
    // S1: round half away from zero on the magnitude, keep the sign separately.
    coef   = i_axis_TDATA[VALUE_WIDTH-1:0];
    abs_in = coef[VALUE_WIDTH-1] ? (~coef + VALUE_WIDTH'(1)) : coef;
    rnd    = abs_in + HALF;
    mag_in = rnd[VALUE_WIDTH-1:SCALE];

    qp_in     = (i_qp == 5'd0) ? 5'd1 : i_qp;
    // Coefficient 0 uses the live QP/mode; the rest of the block uses the latched copy.
    qp_cur    = (idx_q == 6'd0) ? qp_in   : qp_l_q;
    intra_cur = (idx_q == 6'd0) ? i_intra : intra_l_q;

    // S2: INTER applies a dead zone of qp/2 before dividing by 2*qp.
    half_qp = MAG_W'(qp1_q >> 1);
    if (intra1_q)               magp = mag1_q;
    else if (mag1_q > half_qp)  magp = mag1_q - half_qp;
    else                        magp = '0;
    prod  = (MAG_W+16)'(magp) * (MAG_W+16)'(recip_lut(qp1_q));
    q_est = prod[MAG_W+15:16];

    // S3: the truncated reciprocal can undershoot by exactly one; fix it up.
    q_inc     = {1'b0, q2_q} + (MAG_W+1)'(1);
    corr_prod = (MAG_W+7)'(q_inc) * (MAG_W+7)'({qp2_q, 1'b0});
    q_fix     = (corr_prod <= (MAG_W+7)'(magp2_q)) ? q_inc : {1'b0, q2_q};
    mag_lim   = (q_fix > (MAG_W+1)'(127)) ? 7'd127 : q_fix[6:0];
    ac_lvl    = sign2_q ? (OUT_WIDTH'(0) - OUT_WIDTH'(mag_lim)) : OUT_WIDTH'(mag_lim);

    // INTRA DC: (COF+4)>>>3 clipped to 1..254, sent unsigned.
    dc_cof = sign2_q ? -$signed({2'b00, mag2_q}) : $signed({2'b00, mag2_q});
    dc_sum = dc_cof + DC_BIAS;
    dc_shr = dc_sum >>> 3;
    if (dc_shr < DC_MIN)      dc_lvl = 8'd1;
    else if (dc_shr > DC_MAX) dc_lvl = 8'd254;
    else                      dc_lvl = dc_shr[7:0];
    is_dc = intra2_q && (idx2_q == 6'd0);
  end

  // Next-state
  always_comb begin
    idx_d     = idx_q;
    qp_l_d    = qp_l_q;
    intra_l_d = intra_l_q;
    v1_d = v1_q; sign1_d = sign1_q; mag1_d = mag1_q; idx1_d = idx1_q; intra1_d = intra1_q; qp1_d = qp1_q;
    v2_d = v2_q; sign2_d = sign2_q; mag2_d = mag2_q; magp2_d = magp2_q; q2_d = q2_q;
    idx2_d = idx2_q; intra2_d = intra2_q; qp2_d = qp2_q;
    v3_d = v3_q; dat3_d = dat3_q; last3_d = last3_q;
    err_d = accept && (i_axis_TLAST != (idx_q == 6'd63));

    if (accept) begin
      if (idx_q == 6'd0) begin
        qp_l_d    = qp_in;
        intra_l_d = i_intra;
      end
      // Early TLAST resynchronises the block; a missing TLAST at 63 just wraps.
      idx_d = (i_axis_TLAST && (idx_q != 6'd63)) ? 6'd0 : idx_q + 6'd1;
    end

    if (en) begin
      v1_d     = accept;
      sign1_d  = coef[VALUE_WIDTH-1];
      mag1_d   = mag_in;
      idx1_d   = idx_q;
      intra1_d = intra_cur;
      qp1_d    = qp_cur;

      v2_d     = v1_q;
      sign2_d  = sign1_q;
      mag2_d   = mag1_q;
      magp2_d  = magp;
      q2_d     = q_est;
      idx2_d   = idx1_q;
      intra2_d = intra1_q;
      qp2_d    = qp1_q;

      v3_d     = v2_q;
      dat3_d   = is_dc ? OUT_WIDTH'(dc_lvl) : ac_lvl;
      last3_d  = (idx2_q == 6'd63);
    end
  end

`ifdef QUANT_STATS_EN
  logic [6:0] nz_acc_q, nz_acc_d, nz_cnt_q, nz_cnt_d, nz_next;
  logic       done_q, done_d, out_hs;

  assign o_nz_count   = nz_cnt_q;
  assign o_block_done = done_q;

  always_comb begin
    nz_acc_d = nz_acc_q;
    nz_cnt_d = nz_cnt_q;
    out_hs   = v3_q && i_axis_TREADY;
    nz_next  = nz_acc_q + 7'(dat3_q != '0);
    done_d   = out_hs && last3_q;
    if (out_hs) begin
      if (last3_q) begin
        nz_cnt_d = nz_next;
        nz_acc_d = '0;
      end else begin
        nz_acc_d = nz_next;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      nz_acc_q <= '0;
      nz_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      nz_acc_q <= nz_acc_d;
      nz_cnt_q <= nz_cnt_d;
      done_q   <= done_d;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idx_q <= '0; qp_l_q <= '0; intra_l_q <= 1'b0; err_q <= 1'b0;
      v1_q <= 1'b0; sign1_q <= 1'b0; mag1_q <= '0; idx1_q <= '0; intra1_q <= 1'b0; qp1_q <= '0;
      v2_q <= 1'b0; sign2_q <= 1'b0; mag2_q <= '0; magp2_q <= '0; q2_q <= '0;
      idx2_q <= '0; intra2_q <= 1'b0; qp2_q <= '0;
      v3_q <= 1'b0; dat3_q <= '0; last3_q <= 1'b0;
    end else begin
      idx_q <= idx_d; qp_l_q <= qp_l_d; intra_l_q <= intra_l_d; err_q <= err_d;
      v1_q <= v1_d; sign1_q <= sign1_d; mag1_q <= mag1_d; idx1_q <= idx1_d; intra1_q <= intra1_d; qp1_q <= qp1_d;
      v2_q <= v2_d; sign2_q <= sign2_d; mag2_q <= mag2_d; magp2_q <= magp2_d; q2_q <= q2_d;
      idx2_q <= idx2_d; intra2_q <= intra2_d; qp2_q <= qp2_d;
      v3_q <= v3_d; dat3_q <= dat3_d; last3_q <= last3_d;
    end
  end

endmodule

// File: tb/tb_h263_quantizer.sv
module tb_h263_quantizer;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [4:0]  i_qp;
  logic        i_intra;
  logic        i_axis_TVALID;
  logic        o_axis_TREADY;
  logic [23:0] i_axis_TDATA;
  logic        i_axis_TLAST;
  logic        o_axis_TVALID;
  logic        i_axis_TREADY;
  logic [15:0] o_axis_TDATA;
  logic        o_axis_TLAST;
  logic        o_tlast_err;
`ifdef QUANT_STATS_EN
  logic [6:0]  o_nz_count;
  logic        o_block_done;
`endif

  always #5 clk = ~clk;

  h263_quantizer dut (
    .i_clk(clk), .i_reset(i_reset), .i_qp(i_qp), .i_intra(i_intra),
    .i_axis_TVALID(i_axis_TVALID), .o_axis_TREADY(o_axis_TREADY),
    .i_axis_TDATA(i_axis_TDATA), .i_axis_TLAST(i_axis_TLAST),
    .o_axis_TVALID(o_axis_TVALID), .i_axis_TREADY(i_axis_TREADY),
    .o_axis_TDATA(o_axis_TDATA), .o_axis_TLAST(o_axis_TLAST),
`ifdef QUANT_STATS_EN
    .o_nz_count(o_nz_count), .o_block_done(o_block_done),
`endif
    .o_tlast_err(o_tlast_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] sb_q[$];   // {expected TLAST, expected level}
  int pre_q[$];           // directed coefficients for the start of the next block
  int m_idx = 0;
  int m_qp = 1;
  bit m_intra = 1'b0;
  int exp_err = 0;
  int err_seen = 0;
  int rdy_mode = 0;       // 0 always ready, 1 toggle, 2 random, 3 held low
  int gap_max = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference quantizer from the arithmetic definition (true division, no reciprocal).
  function automatic int ref_level(input int x, input int qp, input bit intra, input int idx);
    int a, mag, cof, q, d, dz;
    a   = (x < 0) ? -x : x;
    mag = (a + 64) / 128;
    cof = (x < 0) ? -mag : mag;
    if (intra && idx == 0) begin
      d = cof + 4;
      d = (d >= 0) ? d / 8 : -((-d + 7) / 8);
      if (d < 1)   d = 1;
      if (d > 254) d = 254;
      return d;
    end
    if (intra) q = mag / (2 * qp);
    else begin
      dz = mag - qp / 2;
      if (dz < 0) dz = 0;
      q = dz / (2 * qp);
    end
    if (q > 127) q = 127;
    return (cof < 0) ? -q : q;
  endfunction

  task automatic model_push(input int x, input bit tl, input logic [4:0] qp, input bit intra);
    int lvl;
    if (m_idx == 0) begin
      m_qp    = (qp == 5'd0) ? 1 : int'(qp);
      m_intra = intra;
    end
    lvl = ref_level(x, m_qp, m_intra, m_idx);
    sb_q.push_back({(m_idx == 63), 16'(lvl)});
    if (tl != (m_idx == 63)) exp_err++;
    if (tl && m_idx != 63) m_idx = 0;
    else m_idx = (m_idx + 1) % 64;
  endtask

  function automatic int rand_coef();
    logic [16:0] r;
    r = 17'($urandom);
    if ($urandom_range(0, 1) == 1) return int'($signed(r));
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  // Present one beat; called and returns at posedge+1.
  task automatic send(input int x, input bit tl, input logic [4:0] qp, input bit intra);
    int  t;
    bit  done;
    int  gap;
    t = 0;
    done = 1'b0;
    i_axis_TDATA  = {7'($urandom), 17'(x)};
    i_axis_TLAST  = tl;
    i_qp          = qp;
    i_intra       = intra;
    i_axis_TVALID = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (o_axis_TREADY) begin
        model_push(x, tl, qp, intra);
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) begin
        t++;
        if (t > 1000) begin
          chk("accept_timeout", 0, 1);
          done = 1'b1;
        end
      end
    end
    i_axis_TVALID = 1'b0;
    i_axis_TLAST  = 1'b0;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // One well-formed 64-beat block; QP/mode on the wire are scrambled after beat 0.
  task automatic send_block(input logic [4:0] qp, input bit intra);
    int x;
    for (int i = 0; i < 64; i++) begin
      x = (i < pre_q.size()) ? pre_q[i] : rand_coef();
      send(x, (i == 63), (i == 0) ? qp : 5'($urandom), (i == 0) ? intra : 1'($urandom));
    end
    pre_q.delete();
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_leftover_beats"}, sb_q.size(), 0);
    chk({name, "_tlast_err_count"}, err_seen, exp_err);
  endtask

  // Downstream ready generator
  initial begin
    i_axis_TREADY = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: i_axis_TREADY = 1'b1;
        1: i_axis_TREADY = !i_axis_TREADY;
        2: i_axis_TREADY = 1'($urandom);
        default: i_axis_TREADY = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [15:0] held_d;
    logic        held_l;
    bit          stall;
    logic [16:0] e;
    stall = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (i_reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_tvalid", int'(o_axis_TVALID), 1);
          chk("stall_tdata", int'(o_axis_TDATA), int'(held_d));
          chk("stall_tlast", int'(o_axis_TLAST), int'(held_l));
        end
        if (o_axis_TVALID && i_axis_TREADY) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("level", int'($signed(o_axis_TDATA)), int'($signed(e[15:0])));
            chk("tlast", int'(o_axis_TLAST), int'(e[16]));
          end
        end
        stall  = o_axis_TVALID && !i_axis_TREADY;
        held_d = o_axis_TDATA;
        held_l = o_axis_TLAST;
        if (o_tlast_err) err_seen++;
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, %0d beats outstanding", sb_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    i_reset = 1'b1;
    i_axis_TVALID = 1'b0;
    i_axis_TDATA = '0;
    i_axis_TLAST = 1'b0;
    i_qp = '0;
    i_intra = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", int'(o_axis_TVALID), 0);
    chk("reset_tready", int'(o_axis_TREADY), 0);
    chk("reset_tlast", int'(o_axis_TLAST), 0);
    chk("reset_tdata", int'(o_axis_TDATA), 0);
    chk("reset_tlast_err", int'(o_tlast_err), 0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    // INTRA QP=4: DC 257.08 and AC -145.195
    rdy_mode = 0; gap_max = 0;
    pre_q.push_back(32906); pre_q.push_back(-18585);
    send_block(5'd4, 1'b1);
    drain("intra_qp4");

    // INTER QP=4: -145.195, 3.0 below dead zone
    pre_q.push_back(-18585); pre_q.push_back(384); pre_q.push_back(-384);
    send_block(5'd4, 1'b0);
    // INTER with QP=0 on the wire
    send_block(5'd0, 1'b0);
    // INTER QP=1 saturation
    pre_q.push_back(65408); pre_q.push_back(-64000); pre_q.push_back(-65536); pre_q.push_back(65535);
    send_block(5'd1, 1'b0);
    drain("inter");

    // INTRA DC extremes
    pre_q.push_back(65535);
    send_block(5'd1, 1'b1);
    pre_q.push_back(0);
    send_block(5'd1, 1'b1);
    pre_q.push_back(-65536);
    send_block(5'd31, 1'b1);
    drain("intra_dc");

    // Toggling downstream ready with input gaps
    rdy_mode = 1; gap_max = 3;
    send_block(5'd7, 1'b1);
    send_block(5'd13, 1'b0);
    drain("toggle_ready");

    // Random ready, gaps and QP
    rdy_mode = 2; gap_max = 2;
    for (int b = 0; b < 3; b++) send_block(5'($urandom), 1'($urandom));
    drain("random");

    // Early TLAST on beat 10, then a new block with a different QP
    for (int i = 0; i < 11; i++) send(rand_coef(), (i == 10), 5'd6, 1'b0);
    pre_q.push_back(32906);
    send_block(5'd12, 1'b1);
    drain("early_tlast");

    // Missing TLAST on beat 63
    for (int i = 0; i < 64; i++) send(rand_coef(), 1'b0, (i == 0) ? 5'd3 : 5'($urandom), 1'b0);
    send_block(5'd9, 1'b0);
    drain("missing_tlast");

    // Reset in the middle of a block
    rdy_mode = 0; gap_max = 0;
    for (int i = 0; i < 30; i++) send(rand_coef(), 1'b0, (i == 0) ? 5'd7 : 5'($urandom), 1'b0);
    rdy_mode = 3;
    repeat (3) begin
      @(posedge clk); #1;
    end
    i_reset = 1'b1;
    @(negedge clk);
    chk("midreset_tready", int'(o_axis_TREADY), 0);
    @(posedge clk); #1;
    chk("midreset_tvalid", int'(o_axis_TVALID), 0);
    i_reset = 1'b0;
    sb_q.delete();
    m_idx = 0;
    rdy_mode = 0;
    pre_q.push_back(-18585);
    send_block(5'd4, 1'b1);
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
